led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DEB_W, default 20: debounce counter width; an input change must hold for 2^DEB_W consecutive cycles.
REQ-002 Parameter TICK_W, default 23: base step-divider width; slowest step period is 2^TICK_W cycles.
REQ-003 CLK  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 BTN_MODE  input  1  raw mode pushbutton, asynchronous, active-high.
REQ-006 BTN_SPD  input  1  raw speed pushbutton, asynchronous, active-high.
REQ-007 LED  output  4  registered LED drive, bit 0 = LED0.
REQ-008 MODE  output  2  current mode: 0 OFF, 1 SCAN, 2 BLINK, 3 COUNT.
REQ-009 SPD  output  2  current speed index, 0 = slowest.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level flips only after the synchronized input differs from it for 2^DEB_W consecutive cycles; any agreement cycle restarts the count.
REQ-011 A press event SHALL be a 1-cycle pulse on the cycle after the debounced level rises; release generates nothing.
REQ-012 The mode FSM SHALL advance OFF->SCAN->BLINK->COUNT->OFF, one state per mode press.
REQ-013 A speed press SHALL increment SPD modulo 4 (3->0).
REQ-014 A free-running TICK_W-bit divider SHALL emit a 1-cycle tick when its low (TICK_W-SPD) bits are all ones; period = 2^(TICK_W-SPD) cycles.
REQ-015 On any mode or speed press, the divider SHALL clear to 0 in the same cycle the press takes effect.
REQ-016 A 4-bit step counter SHALL clear on a mode press and advance only on tick: SCAN 0..5 then wrap to 0; BLINK toggles 0/1; COUNT 0..15 then wrap to 0; OFF holds 0.
REQ-017 LED decode, registered one cycle after MODE/step: OFF 0000; SCAN steps 0-5 -> 0001,0010,0100,1000,0100,0010; BLINK step 0 -> 1111, step 1 -> 0000; COUNT -> step value.
REQ-018 Simultaneous mode and speed presses in one cycle SHALL both take effect.
REQ-019 A press coinciding with a tick SHALL win: the step clears or holds per REQ-016, with no advance.
REQ-020 MODE and SPD SHALL update on the cycle after the press pulse.

Reset
REQ-021 RST SHALL set MODE=0, SPD=0, step=0, divider=0, LED=0000, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-022 RST asserted mid-debounce or mid-pattern SHALL discard all progress; no press event is generated for a button held across reset release until it is released and pressed again.

Structure
REQ-023 Mode encodings (OFF/SCAN/BLINK/COUNT) and the SCAN decode table SHALL live in a shared header/package reused by LED-related blocks.
REQ-024 Synchronizer, debouncer and edge detect SHALL form one sub-module, btn_debounce (parameter DEB_W), instantiated twice.

Verification
Bench parameters: DEB_W=4, TICK_W=6.
REQ-025 Debounce: BTN_MODE high for 15 cycles, then low -> no press and MODE stays 0. High for 20 cycles -> exactly one press and MODE=1.
REQ-026 Scan sequence: MODE=1, SPD=0 -> LED steps 0001,0010,0100,1000,0100,0010,0001, one step every 64 cycles.
REQ-027 Speed: four speed presses -> SPD 1,2,3,0. At SPD=3 the step period is 8 cycles, and the divider restarts after each press.
REQ-028 Mode wrap with COUNT: LED counts 0000..1111 then 0000. Two further mode presses -> OFF with LED=0000, then SCAN restarting at 0001.
REQ-029 Simultaneous and reset cases: both buttons pressed together from reset -> MODE=1, SPD=1. RST pulsed mid-COUNT with BTN_MODE held -> all outputs 0 and no press until the button is released and re-pressed.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// Mode encodings and LED decode tables shared by the LED sequencer blocks.
package led_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SCAN  = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_COUNT = 2'd3
   } mode_e;

   localparam logic [3:0] SCAN_LAST  = 4'd5;
   localparam logic [3:0] LED_ALL_ON = 4'b1111;

   // Back-and-forth sweep: 0001 0010 0100 1000 0100 0010
   function automatic logic [3:0] scan_led(input logic [3:0] step);
      logic [3:0] led;
      case (step)
         4'd0:    led = 4'b0001;
         4'd1:    led = 4'b0010;
         4'd2:    led = 4'b0100;
         4'd3:    led = 4'b1000;
         4'd4:    led = 4'b0100;
         4'd5:    led = 4'b0010;
         default: led = 4'b0001;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, counting debouncer and
// rising-edge press pulse.
module btn_debounce #(
   parameter int DEB_W = 20
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   logic             r_sync1;
   logic             r_sync2;
   logic [1:0]       r_vld;
   logic             r_armed;
   logic             r_level;
   logic             r_level_q;
   logic [DEB_W-1:0] r_cnt;
   logic             w_cnt_max;

   assign w_cnt_max = (r_cnt == {DEB_W{1'b1}});

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_vld     <= 2'b00;
         r_armed   <= 1'b0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_vld     <= {r_vld[0], 1'b1};
         r_level_q <= r_level;
         // A button held through reset must be seen released before it may press.
         if (r_vld[1] && !r_sync2)
            r_armed <= 1'b1;
         if (r_sync2 == r_level)
            r_cnt <= '0;
         else if (w_cnt_max) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_press = r_level & ~r_level_q & r_armed;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: two debounced buttons select mode and speed,
// a divider paces the step counter, and the LEDs decode mode/step.
//   state      | meaning
//   MODE_OFF   | all LEDs dark, step held at 0
//   MODE_SCAN  | single LED sweeps 0->3->0, 6 steps
//   MODE_BLINK | all LEDs toggle on/off each step
//   MODE_COUNT | LEDs show a 4-bit binary count
module led_seq_ctrl
   import led_seq_ctrl_pkg::*;
#(
   parameter int DEB_W  = 20,
   parameter int TICK_W = 23
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_MODE,
   input  logic       BTN_SPD,
   output logic [3:0] LED,
   output logic [1:0] MODE,
   output logic [1:0] SPD
);

   mode_e             r_mode;
   mode_e             w_mode_nxt;
   logic [1:0]        r_spd;
   logic [TICK_W-1:0] r_div;
   logic [TICK_W-1:0] w_mask;
   logic              w_tick;
   logic [3:0]        r_step;
   logic [3:0]        w_step_nxt;
   logic [3:0]        r_led;
   logic [3:0]        w_led_nxt;
   logic              w_mode_press;
   logic              w_spd_press;

   btn_debounce #(.DEB_W(DEB_W)) u_btn_mode (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_btn   (BTN_MODE),
      .o_press (w_mode_press)
   );

   btn_debounce #(.DEB_W(DEB_W)) u_btn_spd (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_btn   (BTN_SPD),
      .o_press (w_spd_press)
   );

   always_ff @(posedge CLK) begin
      if (RST)
         r_mode <= MODE_OFF;
      else
         r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_mode_press) begin
         case (r_mode)
            MODE_OFF:   w_mode_nxt = MODE_SCAN;
            MODE_SCAN:  w_mode_nxt = MODE_BLINK;
            MODE_BLINK: w_mode_nxt = MODE_COUNT;
            default:    w_mode_nxt = MODE_OFF;
         endcase
      end
   end

   always_comb begin
      w_led_nxt = 4'b0000;
      case (r_mode)
         MODE_SCAN:  w_led_nxt = scan_led(r_step);
         MODE_BLINK: w_led_nxt = r_step[0] ? 4'b0000 : LED_ALL_ON;
         MODE_COUNT: w_led_nxt = r_step;
         default:    w_led_nxt = 4'b0000;
      endcase
   end

   // Faster speeds watch fewer low divider bits, halving the period per step.
   assign w_mask = {TICK_W{1'b1}} >> r_spd;
   assign w_tick = ((r_div & w_mask) == w_mask);

   // Any press overrides a coincident tick.
   always_comb begin
      w_step_nxt = r_step;
      if (w_mode_press)
         w_step_nxt = 4'd0;
      else if (w_tick && !w_spd_press) begin
         case (r_mode)
            MODE_SCAN:  w_step_nxt = (r_step >= SCAN_LAST) ? 4'd0 : r_step + 4'd1;
            MODE_BLINK: w_step_nxt = {3'b000, ~r_step[0]};
            MODE_COUNT: w_step_nxt = r_step + 4'd1;
            default:    w_step_nxt = 4'd0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_spd  <= 2'd0;
         r_div  <= '0;
         r_step <= 4'd0;
         r_led  <= 4'b0000;
      end else begin
         r_led  <= w_led_nxt;
         r_step <= w_step_nxt;
         if (w_spd_press)
            r_spd <= r_spd + 2'd1;
         if (w_mode_press || w_spd_press)
            r_div <= '0;
         else
            r_div <= r_div + 1'b1;
      end
   end

   assign LED  = r_led;
   assign MODE = r_mode;
   assign SPD  = r_spd;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized self-checking bench for led_seq_ctrl against a step-timing model.
module tb_led_seq_ctrl;

   localparam int DEB_W  = 4;
   localparam int TICK_W = 6;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BTN_MODE;
   logic       BTN_SPD;
   logic [3:0] LED;
   logic [1:0] MODE;
   logic [1:0] SPD;

   led_seq_ctrl #(.DEB_W(DEB_W), .TICK_W(TICK_W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .BTN_MODE (BTN_MODE),
      .BTN_SPD  (BTN_SPD),
      .LED      (LED),
      .MODE     (MODE),
      .SPD      (SPD)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   // Model: since the last press (edge m_e0) the step is m_k0 plus one per period.
   int m_mode, m_spd, m_k0, m_e0;
   int scan_pat [6] = '{1, 2, 4, 8, 4, 2};

   function automatic int seq_len(input int mode);
      case (mode)
         1:       return 6;
         2:       return 2;
         3:       return 16;
         default: return 1;
      endcase
   endfunction

   function automatic int period(input int spd);
      return 1 << (TICK_W - spd);
   endfunction

   function automatic int step_at(input int c);
      return (m_k0 + (c - m_e0) / period(m_spd)) % seq_len(m_mode);
   endfunction

   // LED sampled after edge c shows the step held after edge c-1.
   function automatic logic [3:0] exp_led_at(input int c);
      int s;
      s = step_at(c - 1);
      case (m_mode)
         1:       return 4'(scan_pat[s]);
         2:       return (s == 0) ? 4'b1111 : 4'b0000;
         3:       return 4'(s);
         default: return 4'b0000;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_spd  = 0;
      m_k0   = 0;
      m_e0   = cyc;
   endtask

   task automatic model_event(input bit mp, input bit sp, input int e);
      int k;
      k = step_at(e - 1);
      if (mp) begin
         m_mode = (m_mode + 1) % 4;
         m_k0   = 0;
      end else
         m_k0 = k;
      if (sp)
         m_spd = (m_spd + 1) % 4;
      m_e0 = e;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      model_reset();
   endtask

   // Press the chosen button(s), return the edge at which MODE/SPD moved.
   task automatic press(input bit mp, input bit sp, output int e, output bit ok);
      logic [1:0] pm, ps;
      repeat (20 + $urandom_range(0, 15)) tick();
      pm = MODE;
      ps = SPD;
      BTN_MODE = mp;
      BTN_SPD  = sp;
      ok = 1'b0;
      e  = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if (MODE !== pm || SPD !== ps) begin
            ok = 1'b1;
            e  = cyc;
         end
      end
      BTN_MODE = 1'b0;
      BTN_SPD  = 1'b0;
      if (ok)
         model_event(mp, sp, e);
   endtask

   task automatic test_reset();
      BTN_MODE = 1'b0;
      BTN_SPD  = 1'b0;
      do_reset();
      vectors += 3;
      if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", MODE); end
      if (SPD !== 2'd0) begin errors++; $display("FAIL reset_spd got=%0d exp=0", SPD); end
      if (LED !== 4'b0000) begin errors++; $display("FAIL reset_led got=%b exp=0000", LED); end
   endtask

   task automatic test_debounce();
      int changes;
      logic [1:0] prev;
      do_reset();
      BTN_MODE = 1'b1;
      repeat (15) tick();
      BTN_MODE = 1'b0;
      repeat (30) tick();
      vectors++;
      if (MODE !== 2'd0) begin errors++; $display("FAIL deb_15cyc got=%0d exp=0", MODE); end
      repeat (6) begin
         BTN_MODE = 1'b1;
         repeat ($urandom_range(1, 15)) tick();
         BTN_MODE = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
      end
      repeat (30) tick();
      vectors++;
      if (MODE !== 2'd0) begin errors++; $display("FAIL deb_glitch got=%0d exp=0", MODE); end
      changes = 0;
      prev = MODE;
      BTN_MODE = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i == 20) BTN_MODE = 1'b0;
         tick();
         if (MODE !== prev) changes++;
         prev = MODE;
      end
      vectors += 2;
      if (changes != 1) begin errors++; $display("FAIL deb_20cyc_presses got=%0d exp=1", changes); end
      if (MODE !== 2'd1) begin errors++; $display("FAIL deb_20cyc_mode got=%0d exp=1", MODE); end
   endtask

   task automatic test_scan();
      int e;
      bit ok;
      logic [3:0] x;
      do_reset();
      press(1'b1, 1'b0, e, ok);
      vectors += 2;
      if (!ok) begin errors++; $display("FAIL scan_press timeout got=none exp=event"); end
      if (MODE !== 2'd1) begin errors++; $display("FAIL scan_mode got=%0d exp=1", MODE); end
      repeat (6 * 64 + 2) begin
         tick();
         x = exp_led_at(cyc);
         vectors++;
         if (LED !== x) begin errors++; $display("FAIL scan_led cyc=%0d got=%b exp=%b", cyc, LED, x); end
      end
   endtask

   task automatic test_speed();
      int e;
      bit ok;
      logic [3:0] x;
      for (int i = 0; i < 4; i++) begin
         press(1'b0, 1'b1, e, ok);
         vectors += 2;
         if (!ok) begin errors++; $display("FAIL spd_press%0d timeout got=none exp=event", i); end
         if (SPD !== 2'(m_spd)) begin errors++; $display("FAIL spd_value%0d got=%0d exp=%0d", i, SPD, m_spd); end
         repeat (3 * period(m_spd) + 2) begin
            tick();
            x = exp_led_at(cyc);
            vectors++;
            if (LED !== x) begin errors++; $display("FAIL spd_led cyc=%0d got=%b exp=%b", cyc, LED, x); end
         end
      end
   endtask

   task automatic test_count_wrap();
      int e;
      bit ok;
      logic [3:0] x;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press(1'b1, 1'b0, e, ok);
         vectors++;
         if (!ok) begin errors++; $display("FAIL cnt_enter%0d timeout got=none exp=event", i); end
      end
      vectors++;
      if (MODE !== 2'd3) begin errors++; $display("FAIL cnt_mode got=%0d exp=3", MODE); end
      repeat (16 * 64 + 40) begin
         tick();
         x = exp_led_at(cyc);
         vectors++;
         if (LED !== x) begin errors++; $display("FAIL cnt_led cyc=%0d got=%b exp=%b", cyc, LED, x); end
      end
      press(1'b1, 1'b0, e, ok);
      tick();
      vectors += 2;
      if (MODE !== 2'd0) begin errors++; $display("FAIL cnt_to_off got=%0d exp=0", MODE); end
      if (LED !== 4'b0000) begin errors++; $display("FAIL off_led got=%b exp=0000", LED); end
      press(1'b1, 1'b0, e, ok);
      tick();
      vectors += 2;
      if (MODE !== 2'd1) begin errors++; $display("FAIL off_to_scan got=%0d exp=1", MODE); end
      if (LED !== 4'b0001) begin errors++; $display("FAIL scan_restart got=%b exp=0001", LED); end
   endtask

   task automatic test_simultaneous();
      int e;
      bit ok;
      logic [3:0] x;
      do_reset();
      press(1'b1, 1'b1, e, ok);
      vectors += 3;
      if (!ok) begin errors++; $display("FAIL simul_press timeout got=none exp=event"); end
      if (MODE !== 2'd1) begin errors++; $display("FAIL simul_mode got=%0d exp=1", MODE); end
      if (SPD !== 2'd1) begin errors++; $display("FAIL simul_spd got=%0d exp=1", SPD); end
      repeat (3 * 32 + 2) begin
         tick();
         x = exp_led_at(cyc);
         vectors++;
         if (LED !== x) begin errors++; $display("FAIL simul_led cyc=%0d got=%b exp=%b", cyc, LED, x); end
      end
   endtask

   task automatic test_reset_mid();
      int e;
      int changes;
      bit ok;
      do_reset();
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, e, ok);
      repeat ($urandom_range(100, 300)) tick();
      BTN_MODE = 1'b1;
      repeat (8) tick();
      RST = 1'b1;
      repeat (3) tick();
      vectors += 3;
      if (MODE !== 2'd0) begin errors++; $display("FAIL rstmid_mode got=%0d exp=0", MODE); end
      if (SPD !== 2'd0) begin errors++; $display("FAIL rstmid_spd got=%0d exp=0", SPD); end
      if (LED !== 4'b0000) begin errors++; $display("FAIL rstmid_led got=%b exp=0000", LED); end
      RST = 1'b0;
      model_reset();
      changes = 0;
      for (int i = 0; i < 60; i++) begin
         if (i == 40) BTN_MODE = 1'b0;
         tick();
         if (MODE !== 2'd0) changes++;
      end
      vectors += 2;
      if (changes != 0) begin errors++; $display("FAIL held_press got=%0d exp=0", changes); end
      if (LED !== 4'b0000) begin errors++; $display("FAIL held_led got=%b exp=0000", LED); end
      press(1'b1, 1'b0, e, ok);
      vectors += 2;
      if (!ok) begin errors++; $display("FAIL repress timeout got=none exp=event"); end
      if (MODE !== 2'd1) begin errors++; $display("FAIL repress_mode got=%0d exp=1", MODE); end
   endtask

   task automatic test_random();
      int e;
      int kind;
      bit ok, mp, sp;
      logic [3:0] x;
      do_reset();
      repeat (10) begin
         kind = $urandom_range(0, 2);
         mp = (kind != 1);
         sp = (kind != 0);
         press(mp, sp, e, ok);
         vectors += 3;
         if (!ok) begin errors++; $display("FAIL rnd_press timeout got=none exp=event"); end
         if (MODE !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode got=%0d exp=%0d", MODE, m_mode); end
         if (SPD !== 2'(m_spd)) begin errors++; $display("FAIL rnd_spd got=%0d exp=%0d", SPD, m_spd); end
         repeat ($urandom_range(10, 150)) begin
            tick();
            x = exp_led_at(cyc);
            vectors++;
            if (LED !== x) begin errors++; $display("FAIL rnd_led cyc=%0d got=%b exp=%b", cyc, LED, x); end
         end
      end
   endtask

   initial begin
      RST      = 1'b1;
      BTN_MODE = 1'b0;
      BTN_SPD  = 1'b0;
      model_reset();
      test_reset();
      test_debounce();
      test_scan();
      test_speed();
      test_count_wrap();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
